// File: rtl/radar_core_sweep_mem_master.sv
// Avalon-MM master for the radar sweep table: writes (angle, distance) samples,
// zero-fills the table, and streams it back out in angle order.
`timescale 1ns/1ps
module radar_core_sweep_mem_master #(
    parameter logic [15:0] BASE_ADDR  = 16'h8000,
    parameter int unsigned NUM_ANGLES = 180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        smp_valid,
    output logic        smp_ready,
    input  logic [7:0]  smp_angle,
    input  logic [15:0] smp_dist,
    input  logic        clear_req,
    input  logic        scan_req,
    output logic [15:0] address,
    output logic [3:0]  byteenable,
    output logic        chipselect,
    output logic        write,
    output logic [31:0] writedata,
    output logic        clken,
    input  logic [31:0] readdata,
    output logic        scan_valid,
    output logic [31:0] scan_data,
    output logic [7:0]  scan_angle,
    output logic        scan_last,
    output logic        busy,
    output logic        clear_done,
    output logic        scan_done,
    output logic        err_angle
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_CLR  = 2'd2,
        ST_RD   = 2'd3
    } state_t;

    localparam logic [7:0] NUM_W    = 8'(NUM_ANGLES);
    localparam logic [7:0] LAST_IDX = 8'(NUM_ANGLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        clear_pend_q, clear_pend_d;
    logic        scan_pend_q, scan_pend_d;
    logic        ready_q, ready_d;
    logic [15:0] address_q, address_d;
    logic [31:0] writedata_q, writedata_d;
    logic        chipselect_q, chipselect_d;
    logic        write_q, write_d;
    logic        busy_q, busy_d;
    logic        clear_done_q, clear_done_d;
    logic        err_angle_q, err_angle_d;
    logic        scan_valid_q, scan_valid_d;
    logic [7:0]  scan_angle_q, scan_angle_d;
    logic        scan_last_q, scan_last_d;
    logic        smp_ready_s;
    logic        accept_s;

    // A request arriving this cycle blocks the sample so requests always win.
    assign smp_ready_s = ready_q & ~clear_req & ~scan_req;
    assign accept_s    = smp_valid & smp_ready_s;

    // Next-state, pending-request and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clear_pend_d = clear_pend_q | clear_req;
        scan_pend_d  = scan_pend_q | scan_req;
        address_d    = address_q;
        writedata_d  = writedata_q;
        chipselect_d = 1'b0;
        write_d      = 1'b0;
        clear_done_d = 1'b0;
        err_angle_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clear_pend_q) begin
                    state_d      = ST_CLR;
                    cnt_d        = 8'd0;
                    clear_pend_d = 1'b0;
                end else if (scan_pend_q) begin
                    state_d     = ST_RD;
                    cnt_d       = 8'd0;
                    scan_pend_d = 1'b0;
                end else if (accept_s) begin
                    if (smp_angle < NUM_W) begin
                        state_d     = ST_WR;
                        address_d   = BASE_ADDR + {8'd0, smp_angle};
                        writedata_d = {1'b1, 7'd0, smp_angle, smp_dist};
                    end else begin
                        err_angle_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            ST_CLR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d      = ST_IDLE;
                    clear_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RD: begin
                // cnt_q == NUM_W is the drain cycle for the last read.
                if (cnt_q == NUM_W) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_WR: begin
                chipselect_d = 1'b1;
                write_d      = 1'b1;
            end
            ST_CLR: begin
                chipselect_d = 1'b1;
                write_d      = 1'b1;
                address_d    = BASE_ADDR + {8'd0, cnt_d};
                writedata_d  = 32'd0;
            end
            ST_RD: begin
                if (cnt_d != NUM_W) begin
                    chipselect_d = 1'b1;
                    address_d    = BASE_ADDR + {8'd0, cnt_d};
                end else begin
                    chipselect_d = 1'b0;
                end
            end
            default: begin
                chipselect_d = 1'b0;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE) & ~clear_pend_d & ~scan_pend_d;

        // Read data returns one cycle after the issue, so the scan tags lag by one.
        scan_valid_d = (state_q == ST_RD) && (cnt_q != NUM_W);
        scan_last_d  = scan_valid_d && (cnt_q == LAST_IDX);
        if (scan_valid_d) begin
            scan_angle_d = cnt_q;
        end else begin
            scan_angle_d = scan_angle_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            clear_pend_q <= 1'b0;
            scan_pend_q  <= 1'b0;
            ready_q      <= 1'b0;
            address_q    <= 16'd0;
            writedata_q  <= 32'd0;
            chipselect_q <= 1'b0;
            write_q      <= 1'b0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
            err_angle_q  <= 1'b0;
            scan_valid_q <= 1'b0;
            scan_angle_q <= 8'd0;
            scan_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clear_pend_q <= clear_pend_d;
            scan_pend_q  <= scan_pend_d;
            ready_q      <= ready_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            chipselect_q <= chipselect_d;
            write_q      <= write_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
            err_angle_q  <= err_angle_d;
            scan_valid_q <= scan_valid_d;
            scan_angle_q <= scan_angle_d;
            scan_last_q  <= scan_last_d;
        end
    end

    assign smp_ready  = smp_ready_s;
    assign address    = address_q;
    assign byteenable = 4'hF;
    assign chipselect = chipselect_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign clken      = 1'b1;
    assign scan_valid = scan_valid_q;
    assign scan_data  = scan_valid_q ? readdata : 32'd0;
    assign scan_angle = scan_angle_q;
    assign scan_last  = scan_last_q;
    assign scan_done  = scan_last_q;
    assign busy       = busy_q;
    assign clear_done = clear_done_q;
    assign err_angle  = err_angle_q;

endmodule

// File: tb/tb_radar_core_sweep_mem_master.sv
// Self-checking bench: randomized samples against a sweep-table reference model.
`timescale 1ns/1ps
module tb_radar_core_sweep_mem_master;

    localparam logic [15:0] BASE = 16'h8000;
    localparam int          NA   = 180;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        smp_valid = 1'b0;
    logic        smp_ready;
    logic [7:0]  smp_angle = 8'd0;
    logic [15:0] smp_dist = 16'd0;
    logic        clear_req = 1'b0;
    logic        scan_req = 1'b0;
    logic [15:0] address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic        clken;
    logic [31:0] readdata = 32'd0;
    logic        scan_valid;
    logic [31:0] scan_data;
    logic [7:0]  scan_angle;
    logic        scan_last;
    logic        busy;
    logic        clear_done;
    logic        scan_done;
    logic        err_angle;

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_tab [0:NA-1];
    logic [31:0] mem [0:65535];

    int ev[$];
    logic log_en = 1'b0;
    logic seen_clear = 1'b0;
    int zero_after_clear = 0;
    int nz_after_clear = 0;

    radar_core_sweep_mem_master #(.BASE_ADDR(16'h8000), .NUM_ANGLES(180)) dut (
        .clk(clk), .reset(reset), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_angle(smp_angle), .smp_dist(smp_dist), .clear_req(clear_req),
        .scan_req(scan_req), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .write(write), .writedata(writedata),
        .clken(clken), .readdata(readdata), .scan_valid(scan_valid),
        .scan_data(scan_data), .scan_angle(scan_angle), .scan_last(scan_last),
        .busy(busy), .clear_done(clear_done), .scan_done(scan_done),
        .err_angle(err_angle)
    );

    always #5 clk = ~clk;

    // Single-port memory, read latency 1.
    always @(posedge clk) begin
        if (chipselect && write) mem[address] <= writedata;
        if (chipselect && !write) readdata <= mem[address];
    end

    // Event logger for the back-to-back request scenario.
    always @(negedge clk) begin
        if (log_en) begin
            if (scan_done) ev.push_back(1);
            if (clear_done) begin
                ev.push_back(2);
                seen_clear = 1'b1;
            end
            if (scan_valid && seen_clear) begin
                if (scan_data == 32'd0) zero_after_clear++;
                else nz_after_clear++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({chipselect, write, busy, smp_ready, scan_valid, clear_done, scan_done, err_angle, scan_last} !== 9'd0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0", {chipselect, write, busy, smp_ready, scan_valid, clear_done, scan_done, err_angle, scan_last});
        end
        checks++;
        if (address !== 16'd0 || writedata !== 32'd0 || scan_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus: got addr %h wdata %h sdata %h expected zeros", address, writedata, scan_data);
        end
        checks++;
        if (clken !== 1'b1 || byteenable !== 4'hF) begin
            errors++;
            $display("FAIL reset_const: got clken %b be %h expected 1 F", clken, byteenable);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++;
        if (smp_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready: got %b expected 1", smp_ready);
        end
    endtask

    task automatic do_sample(input logic [7:0] a, input logic [15:0] d);
        logic [31:0] w;
        w = {1'b1, 7'd0, a, d};
        smp_valid = 1'b1;
        smp_angle = a;
        smp_dist = d;
        #1;
        checks++;
        if (smp_ready !== 1'b1) begin
            errors++;
            $display("FAIL smp_ready_idle: got %b expected 1", smp_ready);
        end
        tick();
        smp_valid = 1'b0;
        if (int'(a) < NA) begin
            checks++;
            if (chipselect !== 1'b1 || write !== 1'b1 || err_angle !== 1'b0) begin
                errors++;
                $display("FAIL wr_strobe a=%0d: got cs %b wr %b err %b expected 1 1 0", a, chipselect, write, err_angle);
            end
            checks++;
            if (address !== 16'(BASE + a) || writedata !== w) begin
                errors++;
                $display("FAIL wr_word a=%0d: got %h/%h expected %h/%h", a, address, writedata, 16'(BASE + a), w);
            end
            ref_tab[a] = w;
            #1;
            checks++;
            if (smp_ready !== 1'b0) begin
                errors++;
                $display("FAIL smp_ready_wr: got %b expected 0", smp_ready);
            end
        end else begin
            checks++;
            if (chipselect !== 1'b0 || err_angle !== 1'b1) begin
                errors++;
                $display("FAIL drop a=%0d: got cs %b err %b expected 0 1", a, chipselect, err_angle);
            end
            #1;
            checks++;
            if (smp_ready !== 1'b1) begin
                errors++;
                $display("FAIL smp_ready_drop: got %b expected 1", smp_ready);
            end
        end
        tick();
        checks++;
        if (chipselect !== 1'b0 || err_angle !== 1'b0 || smp_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_sample: got cs %b err %b rdy %b expected 0 0 1", chipselect, err_angle, smp_ready);
        end
    endtask

    task automatic test_sample_write;
        do_sample(8'd5, 16'h0123);
        // The first write is re-checked against the literal bus word.
        checks++;
        if (mem[16'h8005] !== 32'h80050123) begin
            errors++;
            $display("FAIL mem_8005: got %h expected 80050123", mem[16'h8005]);
        end
    endtask

    task automatic test_out_of_range;
        do_sample(8'd200, 16'($urandom));
        do_sample(8'd180, 16'($urandom));
        do_sample(8'd255, 16'($urandom));
        do_sample(8'd179, 16'($urandom));
    endtask

    task automatic test_clear;
        int n;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 0;
        while (!(chipselect && write) && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 10) begin
            errors++;
            $display("FAIL clear_start: got no write in %0d cycles expected one", n);
        end
        for (int i = 0; i < NA; i++) begin
            checks++;
            if (!(chipselect && write && busy) || address !== 16'(BASE + i) || writedata !== 32'd0 || clear_done !== 1'b0) begin
                errors++;
                $display("FAIL clear_wr i=%0d: got cs%b wr%b busy%b %h/%h done%b expected 1 1 1 %h/0 0",
                         i, chipselect, write, busy, address, writedata, clear_done, 16'(BASE + i));
            end
            ref_tab[i] = 32'd0;
            tick();
        end
        checks++;
        if (clear_done !== 1'b1 || chipselect !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_done: got done %b cs %b busy %b expected 1 0 0", clear_done, chipselect, busy);
        end
        tick();
        checks++;
        if (clear_done !== 1'b0) begin
            errors++;
            $display("FAIL clear_done_pulse: got %b expected 0", clear_done);
        end
    endtask

    task automatic test_random_samples;
        do_sample(8'd0, 16'($urandom));
        do_sample(8'd179, 16'($urandom));
        for (int k = 0; k < 24; k++) begin
            do_sample(8'($urandom_range(0, 255)), 16'($urandom));
        end
    endtask

    task automatic test_scan;
        int n;
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        n = 0;
        while (!(chipselect && !write) && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 10) begin
            errors++;
            $display("FAIL scan_start: got no read in %0d cycles expected one", n);
        end
        for (int i = 0; i < NA; i++) begin
            checks++;
            if (chipselect !== 1'b1 || write !== 1'b0 || address !== 16'(BASE + i) || scan_valid !== (i > 0)) begin
                errors++;
                $display("FAIL scan_issue i=%0d: got cs%b wr%b %h sv%b expected 1 0 %h %b",
                         i, chipselect, write, address, scan_valid, 16'(BASE + i), (i > 0));
            end
            if (i > 0) begin
                checks++;
                if (scan_angle !== 8'(i - 1) || scan_data !== ref_tab[i-1] || scan_last !== 1'b0 || scan_done !== 1'b0) begin
                    errors++;
                    $display("FAIL scan_out k=%0d: got ang %0d data %h last %b expected %0d %h 0",
                             i - 1, scan_angle, scan_data, scan_last, i - 1, ref_tab[i-1]);
                end
            end
            tick();
        end
        checks++;
        if (chipselect !== 1'b0 || scan_valid !== 1'b1 || scan_angle !== 8'd179 || scan_data !== ref_tab[NA-1]
            || scan_last !== 1'b1 || scan_done !== 1'b1) begin
            errors++;
            $display("FAIL scan_drain: got cs%b sv%b ang %0d data %h last%b done%b expected 0 1 179 %h 1 1",
                     chipselect, scan_valid, scan_angle, scan_data, scan_last, scan_done, ref_tab[NA-1]);
        end
        tick();
        checks++;
        if (scan_valid !== 1'b0 || scan_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL scan_end: got sv%b done%b busy%b expected 0 0 0", scan_valid, scan_done, busy);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        ev.delete();
        seen_clear = 1'b0;
        zero_after_clear = 0;
        nz_after_clear = 0;
        log_en = 1'b1;
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        repeat (20) tick();
        clear_req = 1'b1;
        scan_req = 1'b1;
        tick();
        clear_req = 1'b0;
        scan_req = 1'b0;
        repeat (20) tick();
        // Repeat while the scan flag is still pending: merged into one scan.
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        cyc = 0;
        while (ev.size() < 3 && cyc < 2000) begin
            tick();
            cyc++;
        end
        repeat (30) tick();
        log_en = 1'b0;
        checks++;
        if (ev.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses expected 3", ev.size());
        end else begin
            checks++;
            if (ev[0] != 1 || ev[1] != 2 || ev[2] != 1) begin
                errors++;
                $display("FAIL b2b_order: got %0d %0d %0d expected 1 2 1", ev[0], ev[1], ev[2]);
            end
        end
        checks++;
        if (zero_after_clear != NA || nz_after_clear != 0) begin
            errors++;
            $display("FAIL b2b_rescan: got %0d zero %0d nonzero expected %0d 0", zero_after_clear, nz_after_clear, NA);
        end
        checks++;
        if (busy !== 1'b0 || smp_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: got busy %b rdy %b expected 0 1", busy, smp_ready);
        end
        for (int i = 0; i < NA; i++) ref_tab[i] = 32'd0;
    endtask

    task automatic test_reset_mid_clear;
        int n;
        int dones;
        int accesses;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 0;
        while (!(chipselect && write && address == 16'h8032) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL rst_mid_reach: got no write to 8032 expected one");
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({chipselect, write, busy, clear_done, smp_ready} !== 5'd0 || address !== 16'd0 || writedata !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b %h %h expected 0 0 0",
                     {chipselect, write, busy, clear_done, smp_ready}, address, writedata);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++;
        if (smp_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_ready: got %b expected 1", smp_ready);
        end
        dones = 0;
        accesses = 0;
        for (int c = 0; c < 200; c++) begin
            if (clear_done) dones++;
            if (chipselect) accesses++;
            tick();
        end
        checks++;
        if (dones != 0 || accesses != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got %0d done %0d access expected 0 0", dones, accesses);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NA; i++) ref_tab[i] = 32'd0;
        test_reset();
        test_sample_write();
        test_out_of_range();
        test_clear();
        test_random_samples();
        test_scan();
        test_back_to_back();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
